// File: rtl/freq_peak_detect.sv
// freq_peak_detect: captures a 16-bin complex FFT frame, scans it through a
// two-stage magnitude/compare pipeline and reports the strongest bin.
// Fixed latency of 18 cycles from fft_valid to done; a new frame can be
// accepted every 16 cycles without stalling the producer.
module freq_peak_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] max_mag,
  output logic        busy
);

  localparam logic [3:0] LAST_BIN = 4'd15;

  // Frame buffer
  logic [31:0] fft_bins [16];
  logic [31:0] frame_d  [16];
  logic [31:0] frame_q  [16];

  // Scan counter
  logic        scan_active_d, scan_active_q;
  logic [3:0]  scan_cnt_d,    scan_cnt_q;

  // Stage 1 (magnitude) registers
  logic [31:0]        sel_bin;
  logic signed [31:0] re_ext, im_ext;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]        mag_sum;
  logic        s1_valid_d, s1_valid_q;
  logic [31:0] s1_mag_d,   s1_mag_q;
  logic [3:0]  s1_idx_d,   s1_idx_q;
  logic        s1_first_d, s1_first_q;
  logic        s1_last_d,  s1_last_q;

  // Stage 2 (compare) and result registers
  logic        take_bin;
  logic [31:0] run_max_d, run_max_q;
  logic [3:0]  run_idx_d, run_idx_q;
  logic        done_d,    done_q;
  logic [3:0]  freq_d,    freq_q;
  logic [31:0] max_mag_d, max_mag_q;
  logic        busy_d,    busy_q;

  assign fft_bins[0]  = fft_d0;
  assign fft_bins[1]  = fft_d1;
  assign fft_bins[2]  = fft_d2;
  assign fft_bins[3]  = fft_d3;
  assign fft_bins[4]  = fft_d4;
  assign fft_bins[5]  = fft_d5;
  assign fft_bins[6]  = fft_d6;
  assign fft_bins[7]  = fft_d7;
  assign fft_bins[8]  = fft_d8;
  assign fft_bins[9]  = fft_d9;
  assign fft_bins[10] = fft_d10;
  assign fft_bins[11] = fft_d11;
  assign fft_bins[12] = fft_d12;
  assign fft_bins[13] = fft_d13;
  assign fft_bins[14] = fft_d14;
  assign fft_bins[15] = fft_d15;

  // Load the whole frame on a capture strobe, otherwise hold
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      frame_d[k] = fft_valid ? fft_bins[k] : frame_q[k];
    end
  end

  // Capture restarts the scan at bin 0; the scan stops after issuing bin 15
  always_comb begin
    scan_active_d = scan_active_q;
    scan_cnt_d    = scan_cnt_q;
    if (fft_valid) begin
      scan_active_d = 1'b1;
      scan_cnt_d    = 4'd0;
    end else if (scan_active_q) begin
      scan_cnt_d = scan_cnt_q + 4'd1;
      if (scan_cnt_q == LAST_BIN) begin
        scan_active_d = 1'b0;
      end
    end
  end

  // Stage 1: squared magnitude of the selected bin. Each square is at most
  // 2^30 so the 32-bit signed products never overflow, and their sum (at most
  // 2^31) fits exactly in an unsigned 32-bit value.
  always_comb begin
    sel_bin    = frame_q[scan_cnt_q];
    re_ext     = {{16{sel_bin[31]}}, sel_bin[31:16]};
    im_ext     = {{16{sel_bin[15]}}, sel_bin[15:0]};
    re_sq      = re_ext * re_ext;
    im_sq      = im_ext * im_ext;
    mag_sum    = $unsigned(re_sq) + $unsigned(im_sq);
    s1_valid_d = scan_active_q;
    s1_mag_d   = mag_sum;
    s1_idx_d   = scan_cnt_q;
    s1_first_d = scan_active_q && (scan_cnt_q == 4'd0);
    s1_last_d  = scan_active_q && (scan_cnt_q == LAST_BIN);
  end

  // Stage 2: running maximum; first bin loads unconditionally, later bins
  // replace only on a strictly larger magnitude so ties keep the lower index
  always_comb begin
    take_bin  = s1_valid_q && (s1_first_q || (s1_mag_q > run_max_q));
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if (take_bin) begin
      run_max_d = s1_mag_q;
      run_idx_d = s1_idx_q;
    end
    done_d    = s1_valid_q && s1_last_q;
    freq_d    = freq_q;
    max_mag_d = max_mag_q;
    if (done_d) begin
      freq_d    = run_idx_d;
      max_mag_d = run_max_d;
    end
    // Busy covers the scan, the stage-1 slot and the done cycle
    busy_d = scan_active_d || s1_valid_d || done_d;
  end

  // Frame buffer has no reset; its contents are qualified by the scan state
  always_ff @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      frame_q[k] <= frame_d[k];
    end
  end

  // Control, pipeline and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_active_q <= 1'b0;
      scan_cnt_q    <= 4'd0;
      s1_valid_q    <= 1'b0;
      s1_mag_q      <= 32'd0;
      s1_idx_q      <= 4'd0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      run_max_q     <= 32'd0;
      run_idx_q     <= 4'd0;
      done_q        <= 1'b0;
      freq_q        <= 4'd0;
      max_mag_q     <= 32'd0;
      busy_q        <= 1'b0;
    end else begin
      scan_active_q <= scan_active_d;
      scan_cnt_q    <= scan_cnt_d;
      s1_valid_q    <= s1_valid_d;
      s1_mag_q      <= s1_mag_d;
      s1_idx_q      <= s1_idx_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      done_q        <= done_d;
      freq_q        <= freq_d;
      max_mag_q     <= max_mag_d;
      busy_q        <= busy_d;
    end
  end

  assign done    = done_q;
  assign freq    = freq_q;
  assign max_mag = max_mag_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_freq_peak_detect.sv
// Testbench for freq_peak_detect: scoreboard of expected frame results,
// pushed as frames are driven and popped when done is due.
module tb_freq_peak_detect;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] max_mag;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_cap = -1000;

  typedef struct {
    int          cap;
    int          due;
    logic [3:0]  f;
    logic [31:0] m;
  } sb_t;
  sb_t sb[$];

  logic [3:0]  cur_freq = 4'd0;
  logic [31:0] cur_mag  = 32'd0;

  freq_peak_detect dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .max_mag(max_mag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the interval after rising edge n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: argmax of re^2+im^2, lowest index on ties
  function automatic void calc(output logic [3:0] f, output logic [31:0] m);
    longint re, im, mg, best;
    best = -1;
    f = 4'd0;
    for (int k = 0; k < 16; k++) begin
      re = longint'($signed(d[k][31:16]));
      im = longint'($signed(d[k][15:0]));
      mg = re * re + im * im;
      if (mg > best) begin
        best = mg;
        f = 4'(k);
      end
    end
    m = best[31:0];
  endfunction

  // Check outputs each cycle, then record the stimulus applied in this cycle
  always @(negedge clk) begin
    logic exp_done;
    logic exp_busy;
    sb_t  ent;
    if (cyc >= 1) begin
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        ent = sb.pop_front();
        cur_freq = ent.f;
        cur_mag  = ent.m;
      end
      chk("freq", 32'(freq), 32'(cur_freq));
      chk("max_mag", max_mag, cur_mag);
      exp_busy = ((cyc - last_cap) >= 1) && ((cyc - last_cap) <= 18);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (!rst) begin
        sb.delete();
        cur_freq = 4'd0;
        cur_mag  = 32'd0;
        last_cap = -1000;
      end else if (fft_valid) begin
        if (sb.size() > 0 && cyc < sb[$].cap + 16) void'(sb.pop_back());
        ent.cap = cyc;
        ent.due = cyc + 18;
        calc(ent.f, ent.m);
        sb.push_back(ent);
        last_cap = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    for (int k = 0; k < 16; k++) d[k] = 32'd0;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) d[k] = $urandom;
  endtask

  // Strobe the current frame for one cycle, then scramble the data lines
  task automatic pulse();
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    rand_frame();
  endtask

  initial begin
    rst = 1'b0;
    fft_valid = 1'b0;
    new_frame();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single peak at bin 5
    new_frame(); d[5] = 32'h0100_0000;
    pulse(); repeat (24) tick();

    // Negative extreme, no overflow
    new_frame(); d[15] = 32'h8000_8000; d[2] = 32'h7FFF_0000;
    pulse(); repeat (24) tick();

    // Tie resolves to lowest index
    new_frame(); d[3] = 32'hFFF0_0010; d[9] = 32'hFFF0_0010; d[0] = 32'h0001_0000;
    pulse(); repeat (24) tick();

    // Back-to-back frames 16 cycles apart
    new_frame(); d[7] = 32'h0040_0040;
    pulse(); repeat (15) tick();
    new_frame(); d[12] = 32'h0000_FF00;
    pulse(); repeat (24) tick();

    // Early restart at cycle 8 abandons frame A
    new_frame(); d[14] = 32'h0200_0000;
    pulse(); repeat (7) tick();
    new_frame(); d[1] = 32'h0000_0300;
    pulse(); repeat (28) tick();

    // Reset mid-scan, then a fresh frame
    new_frame(); d[6] = 32'h0100_0100;
    pulse(); repeat (9) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (9) tick();
    new_frame(); d[11] = 32'hFE00_0000;
    pulse(); repeat (24) tick();

    // All-zero frame
    new_frame();
    pulse(); repeat (24) tick();

    // fft_valid held for three cycles: each cycle restarts
    for (int i = 0; i < 3; i++) begin
      rand_frame();
      fft_valid = 1'b1;
      tick();
    end
    fft_valid = 1'b0;
    repeat (24) tick();

    // Random frames at the full sustained rate
    for (int i = 0; i < 6; i++) begin
      rand_frame();
      pulse(); repeat (15) tick();
    end
    repeat (30) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
